// File: rtl/bsg_vanilla_idiv_iter_pkg.sv
// Shared types for the vanilla core iterative integer divider.
package bsg_vanilla_pkg;

  typedef enum logic [1:0] {
    eDIV  = 2'd0,
    eDIVU = 2'd1,
    eREM  = 2'd2,
    eREMU = 2'd3
  } idiv_op_e;

  typedef enum logic [1:0] {
    eIDLE = 2'd0,
    eCALC = 2'd1,
    eSIGN = 2'd2,
    eDONE = 2'd3
  } idiv_state_e;

  // Signed ops work on magnitudes and fix the signs up afterwards.
  function automatic logic idiv_is_signed(idiv_op_e op);
    return (op == eDIV) || (op == eREM);
  endfunction

  // Quotient-producing ops; the others return the remainder.
  function automatic logic idiv_is_div(idiv_op_e op);
    return (op == eDIV) || (op == eDIVU);
  endfunction

endpackage

// File: rtl/bsg_vanilla_idiv_iter_if.sv
// Request/response bundle between the EXE stage and the iterative divider.
interface bsg_vanilla_idiv_iter_if
  import bsg_vanilla_pkg::*;
#(
  parameter int width_p          = 32,
  parameter int reg_addr_width_p = 5
) ();

  logic                        v_i;
  logic                        ready_o;
  idiv_op_e                    op_i;
  logic [width_p-1:0]          rs1_i;
  logic [width_p-1:0]          rs2_i;
  logic [reg_addr_width_p-1:0] rd_i;
  logic                        flush_i;
  logic                        v_o;
  logic [width_p-1:0]          result_o;
  logic [reg_addr_width_p-1:0] rd_o;
  logic                        yumi_i;

  // Requester / result consumer side.
  modport master (
    output v_i, op_i, rs1_i, rs2_i, rd_i, flush_i, yumi_i,
    input  ready_o, v_o, result_o, rd_o
  );

  // Divider side.
  modport slave (
    input  v_i, op_i, rs1_i, rs2_i, rd_i, flush_i, yumi_i,
    output ready_o, v_o, result_o, rd_o
  );

endinterface

// File: rtl/bsg_vanilla_idiv_iter_step.sv
// One combinational restoring-division step: shift one dividend bit into the
// partial remainder and subtract the divisor if it fits.
module bsg_vanilla_idiv_step #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] rem_i,
  input  logic [width_p-1:0] div_i,
  input  logic               bit_i,
  output logic [width_p-1:0] rem_o,
  output logic               q_o
);

  // Shifted remainder needs one extra bit; the trial compare is width_p+1 wide.
  logic [width_p:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, div_i});
  // When the divisor fits, the difference is below the divisor, so the low
  // width_p bits of the modular subtraction are exact.
  assign rem_o   = q_o ? (shifted[width_p-1:0] - div_i) : shifted[width_p-1:0];

endmodule

// File: rtl/bsg_vanilla_idiv_iter.sv
// Iterative integer divider (DIV/DIVU/REM/REMU) retiring bits_per_iter_p
// quotient bits per cycle. Divide-by-zero and signed overflow skip the loop.
// width_p must be a multiple of bits_per_iter_p (1 or 2).
module bsg_vanilla_idiv_iter
  import bsg_vanilla_pkg::*;
#(
  parameter int width_p          = 32,
  parameter int bits_per_iter_p  = 1,
  parameter int reg_addr_width_p = 5
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bsg_vanilla_idiv_iter_if.slave io
);

  localparam int iters_lp = width_p / bits_per_iter_p;
  localparam int cnt_w_lp = $clog2(iters_lp + 1);

  idiv_state_e                 state_r;
  idiv_op_e                    op_r;
  logic [reg_addr_width_p-1:0] rd_r;
  logic                        neg_q_r;
  logic                        neg_r_r;
  logic [width_p-1:0]          dvd_r;    // dividend in, quotient out
  logic [width_p-1:0]          dvs_r;    // divisor magnitude
  logic [width_p-1:0]          rem_r;    // partial remainder
  logic [width_p-1:0]          result_r;
  logic [cnt_w_lp-1:0]         cnt_r;

  // Request decode, only meaningful while idle.
  logic               req_signed, req_div;
  logic               rs1_neg, rs2_neg;
  logic [width_p-1:0] rs1_abs, rs2_abs;
  logic               div_zero, sgn_ovf;
  logic [width_p-1:0] early_res;

  assign req_signed = idiv_is_signed(io.op_i);
  assign req_div    = idiv_is_div(io.op_i);
  assign rs1_neg    = req_signed & io.rs1_i[width_p-1];
  assign rs2_neg    = req_signed & io.rs2_i[width_p-1];
  assign rs1_abs    = rs1_neg ? (~io.rs1_i + 1'b1) : io.rs1_i;
  assign rs2_abs    = rs2_neg ? (~io.rs2_i + 1'b1) : io.rs2_i;
  assign div_zero   = (io.rs2_i == '0);
  assign sgn_ovf    = req_signed
                    & (io.rs1_i == {1'b1, {(width_p-1){1'b0}}})
                    & (io.rs2_i == '1);
  // x/0 -> all ones, x%0 -> x; MIN/-1 -> MIN, MIN%-1 -> 0.
  assign early_res  = div_zero ? (req_div ? '1 : io.rs1_i)
                               : (req_div ? io.rs1_i : '0);

  // Chain of restoring steps, most significant quotient bit first.
  logic [bits_per_iter_p:0][width_p-1:0] rem_chain;
  logic [bits_per_iter_p-1:0]            q_bits;
  logic [width_p-1:0]                    dvd_next;

  assign rem_chain[0] = rem_r;

  for (genvar k = 0; k < bits_per_iter_p; k++) begin : g_step
    bsg_vanilla_idiv_step #(.width_p(width_p)) u_step (
      .rem_i (rem_chain[k]),
      .div_i (dvs_r),
      .bit_i (dvd_r[width_p-1-k]),
      .rem_o (rem_chain[k+1]),
      .q_o   (q_bits[bits_per_iter_p-1-k])
    );
  end

  // Dividend bits leave from the top as quotient bits enter at the bottom.
  assign dvd_next = {dvd_r[width_p-bits_per_iter_p-1:0], q_bits};

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  logic [width_p-1:0] q_fix, r_fix, final_res;

  assign q_fix     = neg_q_r ? (~dvd_r + 1'b1) : dvd_r;
  assign r_fix     = neg_r_r ? (~rem_r + 1'b1) : rem_r;
  assign final_res = idiv_is_div(op_r) ? q_fix : r_fix;

  // Control FSM and datapath registers; flush beats every other event.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= eIDLE;
      op_r     <= eDIV;
      rd_r     <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dvd_r    <= '0;
      dvs_r    <= '0;
      rem_r    <= '0;
      result_r <= '0;
      cnt_r    <= '0;
    end else if (io.flush_i) begin
      state_r <= eIDLE;
      cnt_r   <= '0;
    end else begin
      unique case (state_r)
        eIDLE: begin
          if (io.v_i) begin
            op_r    <= io.op_i;
            rd_r    <= io.rd_i;
            neg_q_r <= rs1_neg ^ rs2_neg;
            neg_r_r <= rs1_neg;
            dvd_r   <= rs1_abs;
            dvs_r   <= rs2_abs;
            rem_r   <= '0;
            cnt_r   <= '0;
            if (div_zero || sgn_ovf) begin
              result_r <= early_res;
              state_r  <= eDONE;
            end else begin
              state_r  <= eCALC;
            end
          end
        end
        eCALC: begin
          dvd_r <= dvd_next;
          rem_r <= rem_chain[bits_per_iter_p];
          if (cnt_r == cnt_w_lp'(iters_lp - 1)) begin
            cnt_r   <= '0;
            state_r <= eSIGN;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
          end
        end
        eSIGN: begin
          result_r <= final_res;
          state_r  <= eDONE;
        end
        eDONE: begin
          if (io.yumi_i) state_r <= eIDLE;
        end
        default: state_r <= eIDLE;
      endcase
    end
  end

  // Consumer may only take a result that is being offered.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(io.yumi_i && (state_r != eDONE)));
  end

  assign io.ready_o  = (state_r == eIDLE);
  assign io.v_o      = (state_r == eDONE);
  assign io.result_o = result_r;
  assign io.rd_o     = rd_r;

endmodule

// File: tb/tb_bsg_vanilla_idiv_iter.sv
// Directed and randomized checks for the iterative divider: one instance
// retiring 1 bit/cycle, one retiring 2 bits/cycle, sharing one stimulus port.
module tb_bsg_vanilla_idiv_iter;
  import bsg_vanilla_pkg::*;

  logic        clk, rst_n, sel, v_i, flush, yumi;
  idiv_op_e    op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  int          checks, errors;

  bsg_vanilla_idiv_iter_if #(.width_p(32), .reg_addr_width_p(5)) if0 ();
  bsg_vanilla_idiv_iter_if #(.width_p(32), .reg_addr_width_p(5)) if2 ();

  bsg_vanilla_idiv_iter #(.width_p(32), .bits_per_iter_p(1), .reg_addr_width_p(5)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .io(if0.slave));
  bsg_vanilla_idiv_iter #(.width_p(32), .bits_per_iter_p(2), .reg_addr_width_p(5)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .io(if2.slave));

  assign if0.v_i = v_i & ~sel;   assign if2.v_i = v_i & sel;
  assign if0.yumi_i = yumi & ~sel; assign if2.yumi_i = yumi & sel;
  assign if0.op_i = op;   assign if2.op_i = op;
  assign if0.rs1_i = rs1; assign if2.rs1_i = rs1;
  assign if0.rs2_i = rs2; assign if2.rs2_i = rs2;
  assign if0.rd_i = rd;   assign if2.rd_i = rd;
  assign if0.flush_i = flush; assign if2.flush_i = flush;

  wire        ready_w  = sel ? if2.ready_o  : if0.ready_o;
  wire        v_o_w    = sel ? if2.v_o      : if0.v_o;
  wire [31:0] result_w = sel ? if2.result_o : if0.result_o;
  wire [4:0]  rd_w     = sel ? if2.rd_o     : if0.rd_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_idiv(idiv_op_e o, logic [31:0] a, logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      eDIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      eREMU:   return (b == 0) ? a : a % b;
      eDIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      default: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
    endcase
  endfunction

  // Issue one op, wait (bounded) for the result, consume it.
  task automatic run_op(input logic s, input idiv_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output logic ok);
    int t;
    t = 0;
    sel = s; #1;
    while (!ready_w && t < 100) begin @(posedge clk); #1; t++; end
    op = o; rs1 = a; rs2 = b; rd = r; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0; lat = 1;
    while (!v_o_w && lat < 100) begin @(posedge clk); #1; lat++; end
    ok = v_o_w; res = result_w; rdo = rd_w;
    if (ok) begin yumi = 1'b1; @(posedge clk); #1; yumi = 1'b0; end
  endtask

  task automatic test_reset();
    sel = 0; v_i = 0; flush = 0; yumi = 0; op = eDIV; rs1 = 0; rs2 = 0; rd = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if0.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if0.ready_o); end
    checks++; if (if0.v_o !== 1'b0) begin errors++; $display("FAIL reset_v got %b want 0", if0.v_o); end
    checks++; if (if0.result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", if0.result_o); end
    checks++; if (if0.rd_o !== 5'h0) begin errors++; $display("FAIL reset_rd got %h want 0", if0.rd_o); end
    checks++; if (if2.ready_o !== 1'b1 || if2.v_o !== 1'b0) begin errors++; $display("FAIL reset_dut2 got rdy=%b v=%b want 1/0", if2.ready_o, if2.v_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    logic [31:0] res; logic [4:0] rdo; int lat; logic ok;
    run_op(0, eDIV, 32'hFFFF_FFF9, 32'd2, 5'd3, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2 got %h want fffffffd", res); end
    checks++; if (lat != 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    checks++; if (rdo !== 5'd3) begin errors++; $display("FAIL div_rd got %0d want 3", rdo); end
    run_op(0, eREM, 32'hFFFF_FFF9, 32'd2, 5'd4, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2 got %h want ffffffff", res); end
    run_op(0, eDIV, 32'd100, 32'hFFFF_FFF9, 5'd5, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100_m7 got %h want fffffff2", res); end
    run_op(0, eREM, 32'd100, 32'hFFFF_FFF9, 5'd5, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'd2) begin errors++; $display("FAIL rem_100_m7 got %h want 2", res); end
    run_op(0, eREM, 32'hFFFF_FF9C, 32'd7, 5'd6, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem_m100_7 got %h want fffffffe", res); end
  endtask

  task automatic test_div_zero();
    logic [31:0] res; logic [4:0] rdo; int lat; logic ok;
    run_op(0, eDIVU, 32'hFFFF_FFFF, 32'd0, 5'd1, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0 got %h want ffffffff", res); end
    checks++; if (lat != 1) begin errors++; $display("FAIL divu_by0_lat got %0d want 1", lat); end
    run_op(0, eREMU, 32'd5, 32'd0, 5'd2, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'd5 || lat != 1) begin errors++; $display("FAIL remu_by0 got %h lat %0d want 5 lat 1", res, lat); end
    run_op(0, eDIV, 32'd5, 32'd0, 5'd2, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by0 got %h want ffffffff", res); end
    run_op(0, eREM, 32'hFFFF_FFFD, 32'd0, 5'd2, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL rem_by0 got %h want fffffffd", res); end
  endtask

  task automatic test_overflow();
    logic [31:0] res; logic [4:0] rdo; int lat; logic ok;
    run_op(0, eDIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'h8000_0000 || lat != 1) begin errors++; $display("FAIL div_ovf got %h lat %0d want 80000000 lat 1", res, lat); end
    run_op(0, eREM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'h0 || lat != 1) begin errors++; $display("FAIL rem_ovf got %h lat %0d want 0 lat 1", res, lat); end
    run_op(0, eDIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'h0 || lat != 34) begin errors++; $display("FAIL divu_no_ovf got %h lat %0d want 0 lat 34", res, lat); end
    run_op(0, eREMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'h8000_0000) begin errors++; $display("FAIL remu_no_ovf got %h want 80000000", res); end
  endtask

  task automatic test_iter2();
    logic [31:0] res; logic [4:0] rdo; int lat; logic ok;
    run_op(1, eDIVU, 32'd100, 32'd7, 5'd11, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'd14) begin errors++; $display("FAIL divu2_100_7 got %0d want 14", res); end
    checks++; if (lat != 18) begin errors++; $display("FAIL divu2_latency got %0d want 18", lat); end
    run_op(1, eREMU, 32'd100, 32'd7, 5'd11, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'd2) begin errors++; $display("FAIL remu2_100_7 got %0d want 2", res); end
    run_op(1, eDIV, 32'hFFFF_FFF9, 32'd2, 5'd12, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'hFFFF_FFFD || rdo !== 5'd12) begin errors++; $display("FAIL div2_m7_2 got %h rd %0d want fffffffd rd 12", res, rdo); end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; int lat, vcnt; logic ok;
    sel = 0;
    // Handshake in the same cycle as flush must be dropped.
    op = eDIVU; rs1 = 32'd50; rs2 = 32'd5; rd = 5'd1; v_i = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0; flush = 1'b0;
    checks++; if (if0.ready_o !== 1'b1 || if0.v_o !== 1'b0) begin errors++; $display("FAIL flush_hs got rdy=%b v=%b want 1/0", if0.ready_o, if0.v_o); end
    // Kill an op in its fifth calc cycle.
    op = eDIV; rs1 = 32'd100; rs2 = 32'd3; rd = 5'd7; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    repeat (4) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (if0.ready_o !== 1'b1 || if0.v_o !== 1'b0) begin errors++; $display("FAIL flush_calc got rdy=%b v=%b want 1/0", if0.ready_o, if0.v_o); end
    run_op(0, eDIV, 32'd9, 32'd3, 5'd20, res, rdo, lat, ok);
    checks++; if (!ok || res !== 32'd3 || rdo !== 5'd20) begin errors++; $display("FAIL flush_next got %0d rd %0d want 3 rd 20", res, rdo); end
    checks++; if (lat != 34) begin errors++; $display("FAIL flush_next_lat got %0d want 34", lat); end
    vcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (if0.v_o) vcnt++; end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL flush_stray_v got %0d cycles want 0", vcnt); end
  endtask

  task automatic test_hold();
    int t, bad;
    sel = 0; t = 0; bad = 0;
    op = eDIVU; rs1 = 32'd1000; rs2 = 32'd10; rd = 5'd17; v_i = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0;
    while (!if0.v_o && t < 100) begin @(posedge clk); #1; t++; end
    checks++; if (!if0.v_o) begin errors++; $display("FAIL hold_timeout got v=0 want 1"); end
    repeat (10) begin
      @(posedge clk); #1;
      if (if0.v_o !== 1'b1 || if0.result_o !== 32'd100 || if0.rd_o !== 5'd17 || if0.ready_o !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    yumi = 1'b1; #1;
    checks++; if (if0.ready_o !== 1'b0) begin errors++; $display("FAIL hold_no_b2b got rdy=%b want 0", if0.ready_o); end
    @(posedge clk); #1;
    yumi = 1'b0;
    checks++; if (if0.ready_o !== 1'b1 || if0.v_o !== 1'b0) begin errors++; $display("FAIL hold_release got rdy=%b v=%b want 1/0", if0.ready_o, if0.v_o); end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, exp; logic [4:0] rdo, r; int lat, bad, explat, vcnt; logic ok, s, early;
    idiv_op_e o;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      o = idiv_op_e'($urandom_range(0, 3));
      a = $urandom; b = $urandom; r = 5'($urandom);
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      exp = ref_idiv(o, a, b);
      early = (b == 0) || (((o == eDIV) || (o == eREM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      explat = early ? 1 : (s ? 18 : 34);
      run_op(s, o, a, b, r, res, rdo, lat, ok);
      if (!ok || res !== exp || rdo !== r || lat != explat) begin
        bad++;
        if (bad < 5) $display("  random op %0d a=%h b=%h got %h lat %0d want %h lat %0d", o, a, b, res, lat, exp, explat);
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL random_ops got %0d bad of 200 want 0", bad); end
    // Async reset while a result is held drops v_o without a clock edge.
    sel = 0; op = eDIVU; rs1 = 32'd7; rs2 = 32'd0; rd = 5'd3; v_i = 1'b1;
    @(posedge clk); #1; v_i = 1'b0;
    checks++; if (if0.v_o !== 1'b1) begin errors++; $display("FAIL rst_setup got v=%b want 1", if0.v_o); end
    #2 rst_n = 1'b0; #1;
    checks++; if (if0.v_o !== 1'b0 || if0.ready_o !== 1'b1 || if0.result_o !== 32'h0) begin errors++; $display("FAIL rst_async got v=%b rdy=%b res=%h want 0/1/0", if0.v_o, if0.ready_o, if0.result_o); end
    @(posedge clk); #1; rst_n = 1'b1;
    // Reset mid-calculation discards the op entirely.
    op = eDIV; rs1 = 32'd77; rs2 = 32'd7; rd = 5'd9; v_i = 1'b1;
    @(posedge clk); #1; v_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0; #1;
    checks++; if (if0.v_o !== 1'b0 || if0.ready_o !== 1'b1) begin errors++; $display("FAIL rst_midop got v=%b rdy=%b want 0/1", if0.v_o, if0.ready_o); end
    @(posedge clk); #1; rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (if0.v_o) vcnt++; end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL rst_stray_v got %0d cycles want 0", vcnt); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_signed();
    test_div_zero();
    test_overflow();
    test_iter2();
    test_flush();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
